// File: rtl/full_subtractor_fs_cell.sv
// One-bit full subtractor cell: difference and borrow-out from a, b and borrow-in.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when b exceeds a, or a equals b and a borrow is pending.
  assign bo    = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/full_subtractor.sv
// Full subtractor with optional bit-serial mode: borrow-in is the external bin or the
// internal borrow register, and difference/borrow are also provided registered.
module full_subtractor (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic bin,
  input  logic serial,
  input  logic start,
  output logic d,
  output logic bo,
  output logic d_q,
  output logic bo_q,
  output logic borrow_q
);

  logic w_eff_bin;
  logic w_d;
  logic w_bo;
  logic r_d_q;
  logic r_bo_q;
  logic r_borrow_q;

  // The chain is seeded from bin on the LSB (start) or whenever serial mode is off.
  assign w_eff_bin = (serial && !start) ? r_borrow_q : bin;

  fs_cell u_cell (
    .a   (a),
    .b   (b),
    .bin (w_eff_bin),
    .d   (w_d),
    .bo  (w_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_q      <= 1'b0;
      r_bo_q     <= 1'b0;
      r_borrow_q <= 1'b0;
    end else begin
      r_d_q      <= w_d;
      r_bo_q     <= w_bo;
      r_borrow_q <= w_bo;
    end
  end

  assign d        = w_d;
  assign bo       = w_bo;
  assign d_q      = r_d_q;
  assign bo_q     = r_bo_q;
  assign borrow_q = r_borrow_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: reference arithmetic model plus a
// scoreboard of expected register values checked after each clock edge.
module tb_full_subtractor;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic bin;
  logic serial;
  logic start;
  logic d;
  logic bo;
  logic d_q;
  logic bo_q;
  logic borrow_q;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [2:0] sb_q[$];
  logic       m_borrow;
  logic [3:0] diff_acc;

  full_subtractor dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .serial   (serial),
    .start    (start),
    .d        (d),
    .bo       (bo),
    .d_q      (d_q),
    .bo_q     (bo_q),
    .borrow_q (borrow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: arithmetic a - b - bin, independent of the gate equations.
  function automatic logic [1:0] ref_sub(input logic ra, input logic rb, input logic rbin);
    int diff;
    diff = int'(ra) - int'(rb) - int'(rbin);
    return {diff[0], (diff < 0) ? 1'b1 : 1'b0};
  endfunction

  // One cycle: drive at negedge, check combinational outputs, queue expected
  // registers, then check them just after the rising edge.
  task automatic drive_bit(input string tag, input logic ia, input logic ib,
                           input logic ibin, input logic iser, input logic istart,
                           input logic irst);
    logic       eff;
    logic [1:0] exp;
    logic [2:0] got_regs;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; serial = iser; start = istart; rst = irst;
    #1;
    eff = (!iser || istart) ? ibin : m_borrow;
    exp = ref_sub(ia, ib, eff);
    check({tag, " d"},  8'(d),  8'(exp[1]));
    check({tag, " bo"}, 8'(bo), 8'(exp[0]));
    diff_acc = {d, diff_acc[3:1]};
    if (irst) begin
      sb_q.push_back(3'b000);
      m_borrow = 1'b0;
    end else begin
      sb_q.push_back({exp[1], exp[0], exp[0]});
      m_borrow = exp[0];
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s regs: scoreboard empty", tag);
    end else begin
      got_regs = {d_q, bo_q, borrow_q};
      check({tag, " regs"}, 8'(got_regs), 8'(sb_q.pop_front()));
    end
  endtask

  initial begin
    logic [1:0] tbl [8];
    logic [2:0] v;
    tbl = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    n_checks = 0;
    n_pass   = 0;
    m_borrow = 1'b0;
    diff_acc = '0;
    rst = 1'b1; a = 1'b0; b = 1'b0; bin = 1'b0; serial = 1'b0; start = 1'b0;

    @(posedge clk);
    #1;
    check("reset d_q", 8'(d_q), 8'd0);
    check("reset bo_q", 8'(bo_q), 8'd0);
    check("reset borrow_q", 8'(borrow_q), 8'd0);

    // Truth table while held in reset: purely combinational.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a = v[2]; b = v[1]; bin = v[0];
      #1;
      check($sformatf("table %0d", i), 8'({d, bo}), 8'(tbl[i]));
      #4;
    end

    // 5 - 3 = 2, no final borrow.
    drive_bit("s53 b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit("s53 b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("s53 b2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("s53 b3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s53 diff", 8'(diff_acc), 8'd2);
    check("s53 borrow_q", 8'(borrow_q), 8'd0);

    // 3 - 5 = 1110 with final borrow.
    drive_bit("s35 b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit("s35 b1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("s35 b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("s35 b3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s35 diff", 8'(diff_acc), 8'hE);
    check("s35 borrow_q", 8'(borrow_q), 8'd1);

    // Abort mid-operation with reset, then restart.
    drive_bit("abort b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit("abort b1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("abort rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("abort borrow_q", 8'(borrow_q), 8'd0);
    drive_bit("rerun b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit("rerun b1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("rerun b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit("rerun b3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rerun diff", 8'(diff_acc), 8'hE);
    check("rerun borrow_q", 8'(borrow_q), 8'd1);

    // Stale borrow ignored when start re-seeds the chain.
    drive_bit("reseed", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("reseed d", 8'(diff_acc[3]), 8'd1);
    check("reseed borrow_q", 8'(borrow_q), 8'd0);

    // Reset wins over start/serial.
    drive_bit("prime", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit("rst+start", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst+start borrow_q", 8'(borrow_q), 8'd0);

    // start has no effect in parallel mode.
    drive_bit("par start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_bit("par nostart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random mix, including serial toggling and occasional reset.
    for (int i = 0; i < 60; i++) begin
      drive_bit($sformatf("rnd %0d", i), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(3) == 0), 1'($urandom_range(9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
